// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, idle high, 16x oversampled.
// One-deep receive buffer with valid/read handshake, framing and overrun flags.
module uart_rx #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned OVS    = 16
) (
  input  logic       sys_clk_i,
  input  logic       sys_rstn_i,
  input  logic       uart_rx_i,
  input  logic       uart_rd_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  output logic       uart_frame_err_o,
  output logic       uart_overrun_o,
  output logic       uart_busy_o
);

  localparam int unsigned TW = $clog2(OVS);
  localparam logic [31:0] INC = 32'(BAUD * OVS);
  localparam logic [31:0] LIM = 32'(CLK_HZ);
  localparam logic [TW-1:0] HALF = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_e;

  logic          rx_m_q, rx_s_q;
  logic [31:0]   acc_q, acc_d, acc_sum;
  logic          tick;
  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    bitn_q, bitn_d;
  logic [7:0]    shift_q, shift_d;
  logic          deliver, ferr;
  logic [7:0]    dat_q, dat_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          ferr_q;

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      rx_m_q <= uart_rx_i;
      rx_s_q <= rx_m_q;
    end
  end

  // Fractional baud: acc never exceeds LIM + INC, so no 32b overflow.
  always_comb begin
    acc_sum = acc_q + INC;
    tick    = (acc_sum >= LIM);
    acc_d   = tick ? (acc_sum - LIM) : acc_sum;
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bitn_d  = bitn_q;
    shift_d = shift_q;
    deliver = 1'b0;
    ferr    = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            tcnt_d  = '0;
          end
        end
        S_START: begin
          if (tcnt_q == HALF) begin
            if (rx_s_q) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              tcnt_d  = '0;
              bitn_d  = '0;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tcnt_q == LAST) begin
            shift_d[bitn_q] = rx_s_q;
            tcnt_d = '0;
            if (bitn_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              bitn_d = bitn_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tcnt_q == LAST) begin
            tcnt_d = '0;
            if (rx_s_q) begin
              deliver = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr    = 1'b1;
              state_d = S_BRK;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        S_BRK: begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A read in the same cycle as a delivery frees the slot for the new byte.
  always_comb begin
    dat_d   = dat_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (uart_rd_i) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (deliver) begin
      if (!valid_q || uart_rd_i) begin
        dat_d   = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      acc_q   <= '0;
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      bitn_q  <= '0;
      shift_q <= '0;
      dat_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bitn_q  <= bitn_d;
      shift_q <= shift_d;
      dat_q   <= dat_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr;
    end
  end

  assign uart_dat_o       = dat_q;
  assign uart_valid_o     = valid_q;
  assign uart_frame_err_o = ferr_q;
  assign uart_overrun_o   = ovr_q;
  assign uart_busy_o      = (state_q != S_IDLE);

endmodule
